// File: rtl/nios2_debug_scan_pkg.sv
// Shared types and constants for the debug-slave virtual-JTAG scan master.
// Provides scan FSM state encoding, IR command codes and default widths.
// No logic; imported by the tck generator and the scan master top.
package nios2_debug_scan_pkg;

    // Default geometry of the debug-slave scan chain
    localparam int DR_W_DEF = 38;
    localparam int IR_W_DEF = 2;
    localparam int DIV_DEF  = 2;

    // Legacy-compatible raw state codes; the enum below is built on them
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_UIR  = 3'd1;
    localparam logic [2:0] ST_CDR  = 3'd2;
    localparam logic [2:0] ST_SDR  = 3'd3;
    localparam logic [2:0] ST_UDR  = 3'd4;
    localparam logic [2:0] ST_RTI  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        UIR  = ST_UIR,
        CDR  = ST_CDR,
        SDR  = ST_SDR,
        UDR  = ST_UDR,
        RTI  = ST_RTI
    } scan_state_t;

    // Debug-slave instruction register codes
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

endpackage

// File: rtl/nios2_debug_scan_tck_gen.sv
// Scan clock generator: tck toggles every DIV clk cycles while enabled, low otherwise.
// Latency: first rise DIV clk after enable; pulses are combinational, valid the cycle before the tck edge.
// No backpressure; disabling forces tck low and restarts the half-period counter.
module nios2_debug_scan_tck_gen
    import nios2_debug_scan_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tck,
    output logic tck_fall_pulse,
    output logic tck_rise_pulse
);

    // A one-bit counter still works for DIV=1: it simply sits at its last value
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          half_done;

    // The next clk edge ends a tck half-period; the pulse names the edge tck will make there
    assign half_done      = enable && (cnt == CNT_LAST);
    assign tck_rise_pulse = half_done && !tck;
    assign tck_fall_pulse = half_done &&  tck;

    // Half-period counter and tck toggle; idle forces a clean low restart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!enable) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (half_done) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nios2_debug_scan_master.sv
// Debug scan master: runs one IR(+DR) virtual-JTAG command, serializing DR on tdi and capturing tdo.
// Latency: (DR_W+4)*2*DIV clk from accept to rsp_valid, 4*DIV for IR-only commands.
// cmd_ready is high only in IDLE; commands offered while busy are ignored, not queued.
// Build option DEBUG_SCAN_READBACK_EN: defined keeps the tdo capture path and rsp_dr readback;
// undefined removes it (rsp_dr tied 0, tdo unused) with identical timing.
module nios2_debug_scan_master
    import nios2_debug_scan_pkg::*;
#(
    parameter int DR_W = DR_W_DEF,
    parameter int IR_W = IR_W_DEF,
    parameter int DIV  = DIV_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [DR_W-1:0] cmd_dr,
    input  logic            cmd_ir_only,
    output logic            rsp_valid,
    output logic [DR_W-1:0] rsp_dr,
    output logic            tck,
    output logic            tdi,
    input  logic            tdo,
    output logic [IR_W-1:0] ir_in,
    output logic            vs_uir,
    output logic            vs_cdr,
    output logic            vs_sdr,
    output logic            vs_udr,
    output logic            jtag_state_rti
);

    // Wide enough to count all DR_W rises, including the terminal value DR_W
    localparam int BCW = $clog2(DR_W + 1);

    scan_state_t     state;
    logic            ir_only_q;
    logic [DR_W-1:0] sh;
    logic [BCW-1:0]  bit_cnt;
    logic            busy;
    logic            tck_fall;
    logic            tck_rise;
    logic            capture_bit;

    assign busy      = (state != IDLE);
    assign cmd_ready = !busy;

    // State only moves on accept or tck-fall edges, so decoded strobes change only at period starts
    assign vs_uir         = (state == UIR);
    assign vs_cdr         = (state == CDR);
    assign vs_sdr         = (state == SDR);
    assign vs_udr         = (state == UDR);
    assign jtag_state_rti = (state == RTI);

    nios2_debug_scan_tck_gen #(
        .DIV (DIV)
    ) u_tck_gen (
        .clk            (clk),
        .reset          (reset),
        .enable         (busy),
        .tck            (tck),
        .tck_fall_pulse (tck_fall),
        .tck_rise_pulse (tck_rise)
    );

`ifdef DEBUG_SCAN_READBACK_EN
    assign capture_bit = tdo;

    // Publish the captured word as the RTI period closes; held until the next completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_dr <= '0;
        end else if ((state == RTI) && tck_fall) begin
            rsp_dr <= sh;
        end
    end
`else
    // Without readback the shift register only serializes tdi; zeros fill in behind
    logic unused_tdo;
    assign unused_tdo  = tdo;
    assign capture_bit = 1'b0;
    assign rsp_dr      = '0;
`endif

    // Scan FSM: one tck period per state, DR_W periods in SDR; the accept edge starts the UIR period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ir_only_q <= 1'b0;
            ir_in     <= '0;
            tdi       <= 1'b0;
            bit_cnt   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= UIR;
                        ir_in     <= cmd_ir;
                        ir_only_q <= cmd_ir_only;
                        bit_cnt   <= '0;
                    end
                end
                UIR: begin
                    if (tck_fall) begin
                        state <= ir_only_q ? RTI : CDR;
                    end
                end
                CDR: begin
                    if (tck_fall) begin
                        state <= SDR;
                        tdi   <= sh[0];
                    end
                end
                SDR: begin
                    if (tck_rise) begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                    // The rise has already shifted sh, so sh[0] is the next bit to present
                    if (tck_fall) begin
                        if (bit_cnt == BCW'(DR_W)) begin
                            state <= UDR;
                            tdi   <= 1'b0;
                        end else begin
                            tdi <= sh[0];
                        end
                    end
                end
                UDR: begin
                    if (tck_fall) begin
                        state <= RTI;
                    end
                end
                RTI: begin
                    if (tck_fall) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // DR shift register: loaded at accept, shifted right on each SDR tck rise with tdo entering at the top
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh <= '0;
        end else if ((state == IDLE) && cmd_valid) begin
            sh <= cmd_dr;
        end else if ((state == SDR) && tck_rise) begin
            sh <= {capture_bit, sh[DR_W-1:1]};
        end
    end

endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// Self-checking bench for nios2_debug_scan_master: scoreboard of expected responses,
// randomized commands and tdo behaviours, directed reset-abort and back-to-back cases.
// Works in either build of DEBUG_SCAN_READBACK_EN.
`timescale 1ns/1ps
module tb_nios2_debug_scan_master;
    import nios2_debug_scan_pkg::*;

    localparam int TB_DR_W  = 38;
    localparam int TB_IR_W  = 2;
    localparam int TB_DIV   = 2;
    localparam int LAT_FULL = (TB_DR_W + 4) * 2 * TB_DIV;
    localparam int LAT_IR   = 2 * 2 * TB_DIV;
`ifdef DEBUG_SCAN_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [TB_IR_W-1:0] cmd_ir = '0;
    logic [TB_DR_W-1:0] cmd_dr = '0;
    logic               cmd_ir_only = 1'b0;
    logic               rsp_valid;
    logic [TB_DR_W-1:0] rsp_dr;
    logic               tck;
    logic               tdi;
    logic               tdo;
    logic [TB_IR_W-1:0] ir_in;
    logic               vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

    nios2_debug_scan_master #(
        .DR_W (TB_DR_W),
        .IR_W (TB_IR_W),
        .DIV  (TB_DIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_ir         (cmd_ir),
        .cmd_dr         (cmd_dr),
        .cmd_ir_only    (cmd_ir_only),
        .rsp_valid      (rsp_valid),
        .rsp_dr         (rsp_dr),
        .tck            (tck),
        .tdi            (tdi),
        .tdo            (tdo),
        .ir_in          (ir_in),
        .vs_uir         (vs_uir),
        .vs_cdr         (vs_cdr),
        .vs_sdr         (vs_sdr),
        .vs_udr         (vs_udr),
        .jtag_state_rti (jtag_state_rti)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned        accept_cyc;
        int unsigned        lat;
        logic [TB_DR_W-1:0] dr;
        logic [TB_DR_W-1:0] exp_rsp;
        logic [TB_IR_W-1:0] ir;
        bit                 ir_only;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          tdo_mode = 0;

    always @(posedge clk) cyc++;

    // Slave behaviour: 0 loopback, 1 inverted loopback, 2 tied high, 3 tied low
    always_comb begin
        case (tdo_mode)
            0:       tdo = tdi;
            1:       tdo = ~tdi;
            2:       tdo = 1'b1;
            default: tdo = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Captured word: bit k is whatever the slave drove back while tdi carried dr[k]
    function automatic logic [TB_DR_W-1:0] model_rsp(input logic [TB_DR_W-1:0] dr, input int mode);
        logic [TB_DR_W-1:0] w;
        w = '0;
        if (READBACK) begin
            for (int k = 0; k < TB_DR_W; k++) begin
                case (mode)
                    0:       w[k] = dr[k];
                    1:       w[k] = ~dr[k];
                    2:       w[k] = 1'b1;
                    default: w[k] = 1'b0;
                endcase
            end
        end
        return w;
    endfunction

    // Monitor: per-command observations, compared against the scoreboard head on rsp_valid
    int prev_tck = 0;
    int sdr_bits = 0;
    int tdi_bad = 0;
    int shape_bad = 0;
    int seq_code = 0;
    int last_id = -1;

    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        int   nstb;
        int   id;
        if (reset) begin
            prev_tck = 0; sdr_bits = 0; tdi_bad = 0; shape_bad = 0; seq_code = 0; last_id = -1;
        end else begin
            nstb = int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(jtag_state_rti);
            if (nstb != (cmd_ready ? 0 : 1)) shape_bad++;
            if (cmd_ready && tck) shape_bad++;
            if (tck && prev_tck == 0) begin
                id = vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : vs_udr ? 4 : jtag_state_rti ? 5 : 0;
                if (id != last_id) begin
                    seq_code = seq_code * 8 + id;
                    last_id  = id;
                end
                if (vs_sdr) begin
                    if (exp_q.size() > 0 && sdr_bits < TB_DR_W) begin
                        cur = exp_q[0];
                        if (tdi !== cur.dr[sdr_bits]) tdi_bad++;
                    end
                    sdr_bits++;
                end
            end
            prev_tck = int'(tck);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=pulse required=none at cyc %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 64'(cyc - e.accept_cyc), 64'(e.lat));
                    if (!e.ir_only) check("rsp_dr", 64'(rsp_dr), 64'(e.exp_rsp));
                    check("ir_in", 64'(ir_in), 64'(e.ir));
                    check("sdr_bits", 64'(sdr_bits), e.ir_only ? 64'd0 : 64'(TB_DR_W));
                    check("tdi_bits", 64'(tdi_bad), 64'd0);
                    check("strobe_seq", 64'(seq_code), e.ir_only ? 64'o15 : 64'o12345);
                    check("strobe_shape", 64'(shape_bad), 64'd0);
                end
                sdr_bits = 0; tdi_bad = 0; shape_bad = 0; seq_code = 0; last_id = -1;
            end
        end
    end

    // Offer a command, wait (bounded) for acceptance, push the expected response
    task automatic send(input logic [TB_IR_W-1:0] ir, input logic [TB_DR_W-1:0] dr,
                        input bit ir_only, input int mode, input bit hold_valid,
                        output int unsigned acc);
        exp_t e;
        bit   ok;
        @(negedge clk);
        tdo_mode    = mode;
        cmd_ir      = ir;
        cmd_dr      = dr;
        cmd_ir_only = ir_only;
        cmd_valid   = 1'b1;
        ok          = 1'b0;
        acc         = 0;
        for (int n = 0; n < 2000; n++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_ready required=ready");
            cmd_valid = 1'b0;
        end else begin
            e.accept_cyc = cyc + 1;
            e.lat        = ir_only ? LAT_IR : LAT_FULL;
            e.dr         = dr;
            e.exp_rsp    = model_rsp(dr, mode);
            e.ir         = ir;
            e.ir_only    = ir_only;
            exp_q.push_back(e);
            @(posedge clk);
            acc = cyc;
            #1;
            if (!hold_valid) cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tck"}, 64'(tck), 64'd0);
        check({tag, "_strobes"}, 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_dr"}, 64'(rsp_dr), 64'd0);
        check({tag, "_tdi"}, 64'(tdi), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned a1;
        int unsigned a2;
        logic [63:0] r64;

        // Reset state
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_ir_in", 64'(ir_in), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 64'(cmd_ready), 64'd1);

        // Loopback readback of a known word with the BREAK instruction
        send(IR_BREAK, 38'h2A_5A5A_5A5A, 1'b0, 0, 1'b0, a1);
        wait_done();

        // tdo tied high, all-zero DR: tdi stays 0, captured word is all ones
        send(IR_OCIMEM, '0, 1'b0, 2, 1'b0, a1);
        wait_done();

        // IR-only update: UIR then RTI, no DR strobes
        send(IR_TRACECTRL, 38'h15_0000_00FF, 1'b1, 3, 1'b0, a1);
        wait_done();
        check("ir_hold_after_cmd", 64'(ir_in), 64'(IR_TRACECTRL));

        // cmd_valid held through a scan: second command only accepted right after completion
        send(IR_TRACEMEM, 38'h01_2345_6789, 1'b0, 0, 1'b1, a1);
        send(IR_BREAK, 38'h3E_DCBA_9876, 1'b0, 0, 1'b0, a2);
        check("b2b_accept_gap", 64'(a2 - a1), 64'(LAT_FULL + 1));
        wait_done();

        // Reset 50 clk into a scan aborts it without a response
        send(IR_OCIMEM, 38'h2F_0F0F_0F0F, 1'b0, 1, 1'b0, a1);
        repeat (49) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_quiet("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (250) @(negedge clk);
        check("abort_no_rsp_ready", 64'(cmd_ready), 64'd1);

        // Randomized commands across instructions, IR-only mix and slave behaviours
        for (int i = 0; i < 12; i++) begin
            r64 = {$urandom, $urandom};
            send(TB_IR_W'($urandom_range(0, 3)), r64[TB_DR_W-1:0],
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 1'b0, a1);
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
